// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: base mode encodings and mode field width for the LED status controller.
package led_ctrl_pkg;
  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] LED_OFF = 3'd0;
  localparam logic [MODE_W-1:0] LED_ON = 3'd1;
  localparam logic [MODE_W-1:0] LED_FADE = 3'd2;
  localparam logic [MODE_W-1:0] LED_BLINK = 3'd3;
  localparam logic [MODE_W-1:0] LED_FASTBLINK = 3'd4;
endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: first-order PWM, carry of a wrapping accumulator drives the LED.
module led_pwm_channel #(
  parameter int PWMBITS = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [PWMBITS-1:0] bright,
  output logic               led
);
  logic [PWMBITS:0] acc_d;
  logic [PWMBITS-1:0] acc_q;
  logic led_d;
  assign acc_d = {1'b0, acc_q} + {1'b0, bright};
  // full scale forces a steady on; zero gives a steady off
  assign led_d = (&bright) | ((|bright) & acc_d[PWMBITS]);
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q <= '0;
      led <= 1'b0;
    end else begin
      acc_q <= acc_d[PWMBITS-1:0];
      led <= led_d;
    end
  end
endmodule

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: per-LED fault/flash/mode arbitration feeding PWM channels.
// LED_GAMMA_EN adds a registered square-law gamma stage before the PWM.
module led_status_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int PWMBITS = 5,
  parameter int PRESCALE = 20,
  parameter int FLASH_TICKS = 6
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [MODE_W*NUM_LEDS-1:0] mode_i,
  input  logic [NUM_LEDS-1:0]        act_i,
  input  logic [NUM_LEDS-1:0]        fault_i,
  output logic [NUM_LEDS-1:0]        led_o,
  output logic                       tick_o
);
  localparam logic [PWMBITS-1:0] FULL = {PWMBITS{1'b1}};
  logic [PRESCALE-1:0] pre_q;
  logic [7:0] phase_q;
  logic tick;
  logic [PWMBITS-1:0] tri_b, base;
  logic [MODE_W-1:0] md;
  logic flash_on;
  logic [7:0] flash_q [NUM_LEDS];
  logic [7:0] flash_d [NUM_LEDS];
  logic [PWMBITS-1:0] bsel_q [NUM_LEDS];
  logic [PWMBITS-1:0] bsel_d [NUM_LEDS];
  assign tick = &pre_q;
  assign tick_o = tick;
  assign tri_b = phase_q[7] ? phase_q[6 -: PWMBITS] : ~phase_q[6 -: PWMBITS];
  always_comb begin
    md = '0;
    base = '0;
    flash_on = 1'b0;
    for (int n = 0; n < NUM_LEDS; n++) begin
      md = mode_i[MODE_W*n +: MODE_W];
      base = md == LED_ON ? FULL :
             md == LED_FADE ? tri_b :
             md == LED_BLINK ? {PWMBITS{phase_q[7]}} :
             md == LED_FASTBLINK ? {PWMBITS{phase_q[4]}} : '0;
      flash_on = act_i[n] || flash_q[n] != 8'd0;
      bsel_d[n] = fault_i[n] ? {PWMBITS{phase_q[3]}} : flash_on ? (base == '0 ? FULL : '0) : base;
      flash_d[n] = act_i[n] ? 8'(FLASH_TICKS) :
                   (tick && flash_q[n] != 8'd0) ? flash_q[n] - 8'd1 : flash_q[n];
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pre_q <= '0;
      phase_q <= '0;
      flash_q <= '{default: '0};
      bsel_q <= '{default: '0};
    end else begin
      pre_q <= pre_q + PRESCALE'(1);
      phase_q <= phase_q + 8'(tick);
      flash_q <= flash_d;
      bsel_q <= bsel_d;
    end
  end
  for (genvar c = 0; c < NUM_LEDS; c++) begin : g_ch
    logic [PWMBITS-1:0] bright;
`ifdef LED_GAMMA_EN
    logic [2*PWMBITS-1:0] sq;
    logic [PWMBITS-1:0] g_q;
    assign sq = {{PWMBITS{1'b0}}, bsel_q[c]} * {{PWMBITS{1'b0}}, bsel_q[c]};
    always_ff @(posedge clock) begin
      g_q <= !reset_n ? '0 : bsel_q[c] == FULL ? FULL : PWMBITS'(sq >> PWMBITS);
    end
    assign bright = g_q;
`else
    assign bright = bsel_q[c];
`endif
    led_pwm_channel #(.PWMBITS(PWMBITS)) u_ch (
      .clock(clock),
      .reset_n(reset_n),
      .bright(bright),
      .led(led_o[c])
    );
  end
endmodule
